// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data-memory port between the CPU MEM stage and the debug unit.
// Optional alignment rejection is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_arbiter #(
  parameter int NB_DATA    = 32,
  parameter int N_ADDRESS  = 64,
  parameter int NB_ADDRESS = $clog2(N_ADDRESS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [NB_ADDRESS-1:0] i_cpu_addr,
  input  logic [NB_DATA-1:0]    i_cpu_wdata,
  input  logic [1:0]            i_cpu_size,
  output logic                  o_cpu_ack,
  output logic                  o_cpu_err,
  output logic [NB_DATA-1:0]    o_cpu_rdata,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [NB_ADDRESS-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0]    i_dbg_wdata,
  input  logic [1:0]            i_dbg_size,
  output logic                  o_dbg_ack,
  output logic                  o_dbg_err,
  output logic [NB_DATA-1:0]    o_dbg_rdata,
  output logic                  o_mem_r_en,
  output logic                  o_mem_w_en,
  output logic [NB_ADDRESS-1:0] o_mem_addr,
  output logic [NB_DATA-1:0]    o_mem_w_data,
  output logic [1:0]            o_mem_addressing,
  input  logic [NB_DATA-1:0]    i_mem_r_data,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_last_dbg;
  logic                  r_gnt_dbg;
  logic                  r_err;
  logic                  r_mem_r_en;
  logic                  r_mem_w_en;
  logic [NB_ADDRESS-1:0] r_mem_addr;
  logic [NB_DATA-1:0]    r_mem_w_data;
  logic [1:0]            r_mem_size;
  logic                  r_cpu_ack;
  logic                  r_cpu_err;
  logic [NB_DATA-1:0]    r_cpu_rdata;
  logic                  r_dbg_ack;
  logic                  r_dbg_err;
  logic [NB_DATA-1:0]    r_dbg_rdata;

  logic                  w_any_req;
  logic                  w_grant_dbg;
  logic                  w_sel_we;
  logic [NB_ADDRESS-1:0] w_sel_addr;
  logic [NB_DATA-1:0]    w_sel_wdata;
  logic [1:0]            w_sel_size;
  logic                  w_sel_reject;

  function automatic logic f_reject(input logic [1:0] size, input logic [NB_ADDRESS-1:0] addr);
    logic rej;
    rej = (size == 2'b10);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if ((size == 2'b00) && (addr[1:0] != 2'b00)) begin
      rej = 1'b1;
    end else if ((size == 2'b01) && addr[0]) begin
      rej = 1'b1;
    end else begin
      rej = rej;
    end
`else
    rej = rej | (addr[0] & 1'b0);
`endif
    return rej;
  endfunction

  // Grant: lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    w_grant_dbg = 1'b0;
    if (i_cpu_req && i_dbg_req) begin
      w_grant_dbg = ~r_last_dbg;
    end else begin
      w_grant_dbg = i_dbg_req;
    end
  end

  assign w_any_req    = i_cpu_req | i_dbg_req;
  assign w_sel_we     = w_grant_dbg ? i_dbg_we    : i_cpu_we;
  assign w_sel_addr   = w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
  assign w_sel_wdata  = w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
  assign w_sel_size   = w_grant_dbg ? i_dbg_size  : i_cpu_size;
  assign w_sel_reject = f_reject(w_sel_size, w_sel_addr);

  // Sequencer FSM; memory strobes and acks are registered so reset clears them asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_last_dbg   <= 1'b1;
      r_gnt_dbg    <= 1'b0;
      r_err        <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_w_data <= '0;
      r_mem_size   <= 2'b00;
      r_cpu_ack    <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_ack    <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state      <= ACCESS;
            r_busy       <= 1'b1;
            r_gnt_dbg    <= w_grant_dbg;
            r_last_dbg   <= w_grant_dbg;
            r_err        <= w_sel_reject;
            r_mem_r_en   <= ~w_sel_we & ~w_sel_reject;
            r_mem_w_en   <= w_sel_we & ~w_sel_reject;
            r_mem_addr   <= w_sel_addr;
            r_mem_w_data <= w_sel_wdata;
            r_mem_size   <= w_sel_size;
          end
        end
        ACCESS: begin
          r_state      <= RESP;
          r_mem_r_en   <= 1'b0;
          r_mem_w_en   <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_w_data <= '0;
          r_mem_size   <= 2'b00;
          // Writes and rejected accesses return zero data.
          if (r_gnt_dbg) begin
            r_dbg_ack   <= 1'b1;
            r_dbg_err   <= r_err;
            r_dbg_rdata <= r_mem_r_en ? i_mem_r_data : '0;
          end else begin
            r_cpu_ack   <= 1'b1;
            r_cpu_err   <= r_err;
            r_cpu_rdata <= r_mem_r_en ? i_mem_r_data : '0;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_cpu_ack <= 1'b0;
          r_cpu_err <= 1'b0;
          r_dbg_ack <= 1'b0;
          r_dbg_err <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_ack        = r_cpu_ack;
  assign o_cpu_err        = r_cpu_err;
  assign o_cpu_rdata      = r_cpu_rdata;
  assign o_dbg_ack        = r_dbg_ack;
  assign o_dbg_err        = r_dbg_err;
  assign o_dbg_rdata      = r_dbg_rdata;
  assign o_mem_r_en       = r_mem_r_en;
  assign o_mem_w_en       = r_mem_w_en;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_w_data     = r_mem_w_data;
  assign o_mem_addressing = r_mem_size;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small word-memory model.
module tb_data_mem_arbiter;
  localparam int NB_DATA = 32;
  localparam int NB_ADDRESS = 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cpu_req = 1'b0, cpu_we = 1'b0;
  logic [NB_ADDRESS-1:0] cpu_addr = 6'd0;
  logic [NB_DATA-1:0]    cpu_wdata = 32'd0;
  logic [1:0]            cpu_size = 2'b00;
  logic                  dbg_req = 1'b0, dbg_we = 1'b0;
  logic [NB_ADDRESS-1:0] dbg_addr = 6'd0;
  logic [NB_DATA-1:0]    dbg_wdata = 32'd0;
  logic [1:0]            dbg_size = 2'b00;
  logic                  cpu_ack, cpu_err, dbg_ack, dbg_err;
  logic [NB_DATA-1:0]    cpu_rdata, dbg_rdata;
  logic                  mem_r_en, mem_w_en, busy;
  logic [NB_ADDRESS-1:0] mem_addr;
  logic [NB_DATA-1:0]    mem_w_data, mem_r_data;
  logic [1:0]            mem_addressing;

  logic [NB_DATA-1:0]    mem [16];
  logic                  mem_clr = 1'b1;
  int                    n_asserts = 0;
  int                    n_fail = 0;

  data_mem_arbiter #(.NB_DATA(NB_DATA), .N_ADDRESS(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_size(cpu_size),
    .o_cpu_ack(cpu_ack), .o_cpu_err(cpu_err), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .i_dbg_size(dbg_size),
    .o_dbg_ack(dbg_ack), .o_dbg_err(dbg_err), .o_dbg_rdata(dbg_rdata),
    .o_mem_r_en(mem_r_en), .o_mem_w_en(mem_w_en), .o_mem_addr(mem_addr),
    .o_mem_w_data(mem_w_data), .o_mem_addressing(mem_addressing),
    .i_mem_r_data(mem_r_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Word memory: write on the edge that ends the strobe cycle, asynchronous read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else if (mem_w_en) begin
      mem[mem_addr[5:2]] <= mem_w_data;
    end
  end
  assign mem_r_data = mem[mem_addr[5:2]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset, then 10 idle cycles with every output low.
    @(negedge clk);
    check("reset_outputs", {cpu_ack, cpu_err, dbg_ack, dbg_err, mem_r_en, mem_w_en, busy,
                            mem_addressing, mem_addr, cpu_rdata, dbg_rdata, mem_w_data != 32'd0},
          64'd0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_outputs", {cpu_ack, cpu_err, dbg_ack, dbg_err, mem_r_en, mem_w_en, busy,
                             mem_addressing, mem_addr, cpu_rdata != 32'd0, dbg_rdata != 32'd0,
                             mem_w_data != 32'd0}, 64'd0);
    end

    // CPU word write 0x08.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h08; cpu_wdata = 32'hDEADBEEF; cpu_size = 2'b00;
    cyc();
    cpu_req = 1'b0;
    check("wr_access", {mem_w_en, mem_r_en, busy, cpu_ack, mem_addressing, mem_addr, mem_w_data},
          {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'h08, 32'hDEADBEEF});
    cyc();
    check("wr_resp", {mem_w_en, cpu_ack, cpu_err, dbg_ack, cpu_rdata, busy},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1});
    cyc();
    check("wr_back_idle", {busy, cpu_ack, mem_w_en}, {1'b0, 1'b0, 1'b0});

    // CPU word read 0x08.
    cpu_req = 1'b1; cpu_we = 1'b0;
    cyc();
    cpu_req = 1'b0;
    check("rd_access", {mem_r_en, mem_w_en, mem_addr}, {1'b1, 1'b0, 6'h08});
    cyc();
    check("rd_resp", {cpu_ack, cpu_err, mem_r_en, cpu_rdata}, {1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
    cyc();

    // DBG reserved size code.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'h0C; dbg_wdata = 32'h12345678; dbg_size = 2'b10;
    cyc();
    dbg_req = 1'b0;
    check("rsvd_no_strobe", {mem_w_en, mem_r_en, busy}, {1'b0, 1'b0, 1'b1});
    cyc();
    check("rsvd_resp", {dbg_ack, dbg_err, cpu_ack, dbg_rdata}, {1'b1, 1'b1, 1'b0, 32'd0});
    cyc();
    check("rsvd_mem_untouched", {32'd0, mem[3]}, 64'd0);

    // Simultaneous held reads: CPU from 0x08, DBG from 0x0C; last grant was DBG.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h08; cpu_size = 2'b00;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'h0C; dbg_size = 2'b00;
    for (int k = 0; k < 4; k++) begin
      logic exp_dbg;
      exp_dbg = (k % 2) == 1;
      cyc();
      check("tie_access", {mem_r_en, mem_addr}, {1'b1, exp_dbg ? 6'h0C : 6'h08});
      cyc();
      check("tie_ack", {cpu_ack, dbg_ack, cpu_err, dbg_err}, {~exp_dbg, exp_dbg, 1'b0, 1'b0});
      if (exp_dbg) check("tie_dbg_rdata", {32'd0, dbg_rdata}, 64'd0);
      else         check("tie_cpu_rdata", {32'd0, cpu_rdata}, {32'd0, 32'hDEADBEEF});
      @(posedge clk);
    end
    @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0;
    cyc();
    check("tie_done_idle", {busy, cpu_ack, dbg_ack}, {1'b0, 1'b0, 1'b0});

    // Misaligned word read at 0x05.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h05; cpu_size = 2'b00;
    cyc();
    cpu_req = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    check("misalign_no_strobe", {mem_r_en, mem_w_en}, {1'b0, 1'b0});
    cyc();
    check("misalign_resp", {cpu_ack, cpu_err, cpu_rdata}, {1'b1, 1'b1, 32'd0});
`else
    check("misalign_strobe", {mem_r_en, mem_addr}, {1'b1, 6'h05});
    cyc();
    check("misalign_resp", {cpu_ack, cpu_err, cpu_rdata}, {1'b1, 1'b0, 32'h12345678 & 32'd0 | mem[1]});
`endif
    cyc();

    // Reset during the ACCESS cycle of a write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h10; cpu_wdata = 32'hCAFEF00D; cpu_size = 2'b00;
    cyc();
    check("rst_pre_strobe", {mem_w_en}, {1'b1});
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", {mem_w_en, mem_r_en, busy, cpu_ack, dbg_ack}, 64'd0);
    cpu_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_no_ack", {busy, cpu_ack, dbg_ack, mem_w_en}, 64'd0);
    end
    check("rst_write_lost", {32'd0, mem[4]}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
